pc_sequencer: RTL

// - Parametrised program-counter sequencer for the fetch stage of the pipelined MIPS core.
// - Holds the PC register and steps it by STEP each cycle.
// - Honours pipeline stalls and applies branch/jump redirects.
// - Captures redirects that arrive during a stall and replays them when the stall ends.
// - Drives pc_out to instruction memory and pc_plus_out to the IF/ID register.

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-stage bus between the pipeline control and the PC sequencer.
// The master side issues stalls and redirects, and the slave side returns the fetch address and status.
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             br_taken;
    logic [WIDTH-1:0] br_target;
    logic             jmp;
    logic [WIDTH-1:0] jmp_target;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_plus_out;
    logic             valid;
    logic             flush;
    logic             redirect_pending;
    logic             misalign;

    modport master (
        output stall, br_taken, br_target, jmp, jmp_target,
        input  pc_out, pc_plus_out, valid, flush, redirect_pending, misalign
    );

    modport slave (
        input  stall, br_taken, br_target, jmp, jmp_target,
        output pc_out, pc_plus_out, valid, flush, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage. It handles stalls and branch/jump redirects, and it replays redirects that were captured during a stall.
// Optional target alignment check: define PC_ALIGN_CHK_EN.
module pc_sequencer #(
    parameter int unsigned      WIDTH      = 32,
    parameter int unsigned      STEP       = 1,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter int unsigned      ALIGN_BITS = 0
) (
    input logic           clk,
    input logic           rst_n,
    pc_sequencer_if.slave bus
);
`ifdef PC_ALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic {RUN, PEND} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus_q, pc_plus_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pend_is_br_q, pend_is_br_d;
    logic             valid_q, flush_q, flush_d, mis_q, mis_d;
    logic             redirect;
    logic [WIDTH-1:0] sel_raw, rel_raw;

    function automatic logic [WIDTH-1:0] align_tgt(input logic [WIDTH-1:0] raw);
        return CHK_EN ? (raw & ~ALIGN_MASK) : raw;
    endfunction

    function automatic logic tgt_bad(input logic [WIDTH-1:0] raw);
        return CHK_EN && ((raw & ALIGN_MASK) != '0);
    endfunction

    // The branch comes from the older instruction, so it wins over a jump in the same cycle.
    assign redirect = bus.br_taken | bus.jmp;
    assign sel_raw  = bus.br_taken ? bus.br_target : bus.jmp_target;
    assign rel_raw  = bus.br_taken ? bus.br_target : pend_tgt_q;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        pc_plus_d    = pc_plus_q;
        pend_tgt_d   = pend_tgt_q;
        pend_is_br_d = pend_is_br_q;
        flush_d      = 1'b0;
        mis_d        = 1'b0;
        if (valid_q) begin
            unique case (state_q)
                RUN: begin
                    if (!bus.stall) begin
                        if (redirect) begin
                            pc_d      = align_tgt(sel_raw);
                            pc_plus_d = align_tgt(sel_raw) + STEP_W;
                            flush_d   = 1'b1;
                            mis_d     = tgt_bad(sel_raw);
                        end else begin
                            pc_d      = pc_plus_q;
                            pc_plus_d = pc_plus_q + STEP_W;
                        end
                    end else if (redirect) begin
                        pend_tgt_d   = align_tgt(sel_raw);
                        pend_is_br_d = bus.br_taken;
                        mis_d        = tgt_bad(sel_raw);
                        state_d      = PEND;
                    end
                end
                PEND: begin
                    if (bus.stall) begin
                        if (bus.br_taken) begin
                            pend_tgt_d   = align_tgt(bus.br_target);
                            pend_is_br_d = 1'b1;
                            mis_d        = tgt_bad(bus.br_target);
                        end else if (bus.jmp && !pend_is_br_q) begin
                            pend_tgt_d = align_tgt(bus.jmp_target);
                            mis_d      = tgt_bad(bus.jmp_target);
                        end
                    end else begin
                        // A jump arriving on release is dropped because the flush kills its instruction.
                        pc_d      = align_tgt(rel_raw);
                        pc_plus_d = align_tgt(rel_raw) + STEP_W;
                        flush_d   = 1'b1;
                        mis_d     = tgt_bad(rel_raw);
                        state_d   = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= RESET_VEC;
            pc_plus_q    <= RESET_VEC + STEP_W;
            pend_tgt_q   <= '0;
            pend_is_br_q <= 1'b0;
            valid_q      <= 1'b0;
            flush_q      <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            // NOTE: use non-blocking assignments so that all state updates together on the clock edge.
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_plus_q    <= pc_plus_d;
            pend_tgt_q   <= pend_tgt_d;
            pend_is_br_q <= pend_is_br_d;
            valid_q      <= 1'b1;
            flush_q      <= flush_d;
            mis_q        <= mis_d;
        end
    end

    assign bus.pc_out           = pc_q;
    assign bus.pc_plus_out      = pc_plus_q;
    assign bus.valid            = valid_q;
    assign bus.flush            = flush_q;
    assign bus.redirect_pending = (state_q == PEND);
    assign bus.misalign         = mis_q;
endmodule
